// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction for the EX stage. It detects a load in EX
// whose destination (rt) is a source of the instruction in ID, raises
// o_stall and inserts one bubble. A taken branch/jump (i_flush) kills the
// ID instruction and takes priority over the bubble.
// Optional feature: define ID_EX_BUBBLE_STATS_EN to build a saturating
// 16-bit counter of inserted bubbles. Without it, o_bubble_count is tied
// to zero and no counter flops exist.
module id_ex_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_CTRL = 11
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_sext_imm,
  input  logic [NB_DATA-1:0] i_pc_plus4,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_sext_imm,
  output logic [NB_DATA-1:0] o_pc_plus4,
  output logic [NB_ADDR-1:0] o_rs_addr,
  output logic [NB_ADDR-1:0] o_rt_addr,
  output logic [NB_ADDR-1:0] o_rd_addr,
  output logic               o_valid,
  output logic               o_stall,
  output logic [15:0]        o_bubble_count
);

  // Control bundle bit carrying "data memory read" (i.e. the EX op is a load).
  localparam int CTRL_MEM_RD_BIT = 4;

  logic               valid_q,    valid_d;
  logic [NB_CTRL-1:0] ctrl_q,     ctrl_d;
  logic [NB_DATA-1:0] rs_data_q,  rs_data_d;
  logic [NB_DATA-1:0] rt_data_q,  rt_data_d;
  logic [NB_DATA-1:0] sext_imm_q, sext_imm_d;
  logic [NB_DATA-1:0] pc_plus4_q, pc_plus4_d;
  logic [NB_ADDR-1:0] rs_addr_q,  rs_addr_d;
  logic [NB_ADDR-1:0] rt_addr_q,  rt_addr_d;
  logic [NB_ADDR-1:0] rd_addr_q,  rd_addr_d;

  logic hazard;
  logic ex_is_load;
  logic rt_nonzero;
  logic rt_matches_id;

  // Load-use hazard: built only from registered EX state and current ID
  // inputs, so there is no loop through o_stall. Writes to r0 never hazard.
  always_comb begin
    ex_is_load    = valid_q & ctrl_q[CTRL_MEM_RD_BIT];
    rt_nonzero    = (rt_addr_q != '0);
    rt_matches_id = (rt_addr_q == i_rs_addr) | (rt_addr_q == i_rt_addr);
    hazard        = ex_is_load & i_valid & rt_nonzero & rt_matches_id;
  end

  assign o_stall = hazard & ~i_flush;

  // Next-state: hold when disabled; else flush > bubble > capture.
  // Flush and bubble both only kill the slot; data/address fields hold.
  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    sext_imm_d = sext_imm_q;
    pc_plus4_d = pc_plus4_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    rd_addr_d  = rd_addr_q;
    if (i_enable) begin
      if (i_flush || hazard) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d    = i_valid;
        ctrl_d     = i_valid ? i_ctrl : '0;
        rs_data_d  = i_rs_data;
        rt_data_d  = i_rt_data;
        sext_imm_d = i_sext_imm;
        pc_plus4_d = i_pc_plus4;
        rs_addr_d  = i_rs_addr;
        rt_addr_d  = i_rt_addr;
        rd_addr_d  = i_rd_addr;
      end
    end
  end

  // EX-stage register bank with asynchronous clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      sext_imm_q <= '0;
      pc_plus4_q <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      sext_imm_q <= sext_imm_d;
      pc_plus4_q <= pc_plus4_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_ctrl     = ctrl_q;
  assign o_rs_data  = rs_data_q;
  assign o_rt_data  = rt_data_q;
  assign o_sext_imm = sext_imm_q;
  assign o_pc_plus4 = pc_plus4_q;
  assign o_rs_addr  = rs_addr_q;
  assign o_rt_addr  = rt_addr_q;
  assign o_rd_addr  = rd_addr_q;

`ifdef ID_EX_BUBBLE_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Count enabled edges that insert a bubble (flushes excluded); saturate.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (i_enable && !i_flush && hazard && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  // Bubble counter register with asynchronous clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_bubble_count = bubble_cnt_q;
`else
  assign o_bubble_count = '0;
`endif

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, datapath width.
REQ-002 SHALL have parameter NB_ADDR, default 5, register-file address width.
REQ-003 SHALL have parameter NB_CTRL, default 11, control bundle width.
REQ-004 Ctrl bundle bit map SHALL be fixed:
- [0] rf_wr_data_src, [1] rf_wr_addr_src, [2] rf_wr_enb, [3] branch
- [4] data_mem_rd_enb, [5] data_mem_wr_enb, [6] alu_data_src
- [8:7] alu_operation, [9] signed_operation, [10] inmediate_operation
REQ-005 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port i_clock, input, 1, sole clock, rising edge.
REQ-007 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_enable, input, 1, pipeline advance enable (debug step).
REQ-009 SHALL have port i_flush, input, 1, taken branch/jump; kill ID instruction.
REQ-010 SHALL have port i_valid, input, 1, ID slot holds a real instruction.
REQ-011 SHALL have port i_ctrl, input, NB_CTRL, decoded control bundle.
REQ-012 SHALL have ports i_rs_data, i_rt_data, i_sext_imm, i_pc_plus4, input, NB_DATA each, ID operands.
REQ-013 SHALL have ports i_rs_addr, i_rt_addr, i_rd_addr, input, NB_ADDR each, ID register addresses.
REQ-014 SHALL have ports o_ctrl, o_rs_data, o_rt_data, o_sext_imm, o_pc_plus4, o_rs_addr, o_rt_addr, o_rd_addr, output, same widths as their inputs, registered EX-stage copies.
REQ-015 SHALL have port o_valid, output, 1, EX slot holds a real instruction.
REQ-016 SHALL have port o_stall, output, 1, load-use hazard; IF/ID and PC hold.
REQ-017 SHALL have port o_bubble_count, output, 16, hazard bubble count.

Function
REQ-018 hazard SHALL be combinational and equal to:
- o_valid & o_ctrl[4] & i_valid & (o_rt_addr != 0)
- & ((o_rt_addr == i_rs_addr) | (o_rt_addr == i_rt_addr))
REQ-019 o_stall SHALL equal hazard & ~i_flush, with zero latency.
REQ-020 With i_enable=0, all registers and the counter SHALL hold, regardless of i_flush or hazard.
REQ-021 With i_enable=1, each rising edge SHALL apply exactly one action, in priority order: flush > bubble > capture.
REQ-022 Flush (i_flush=1) SHALL clear o_valid and o_ctrl to 0; data and address registers hold.
REQ-023 Bubble (hazard=1, i_flush=0) SHALL clear o_valid and o_ctrl to 0; data and address registers hold.
REQ-024 Capture SHALL load every i_* field into its o_* register.
REQ-025 Capture SHALL set o_valid=i_valid and o_ctrl=(i_valid ? i_ctrl : 0).
REQ-026 A single load-use hazard SHALL produce exactly one bubble cycle: after the bubble, EX holds no load, so the held ID instruction is captured on the next enabled edge.
REQ-027 A hazard on rt=0 SHALL produce no stall.
REQ-028 A store in EX (ctrl[5]) SHALL never cause a stall.
REQ-029 Back-to-back loads with a dependency SHALL each stall once.
REQ-030 Hazard evaluation SHALL use only registered EX state and current ID inputs; no combinational path from o_stall back into hazard.

Reset
REQ-031 i_reset=1 SHALL immediately clear, without waiting for a clock edge: all o_* registers to 0, o_valid=0, o_bubble_count=0.
REQ-032 Consequently, o_stall SHALL be 0 during reset.
REQ-033 A reset asserted mid-stall SHALL discard the pending bubble.
REQ-034 After release, the first enabled edge SHALL perform a normal capture.

Configuration
REQ-035 Macro ID_EX_BUBBLE_STATS_EN SHALL control the bubble counter.
REQ-036 With ID_EX_BUBBLE_STATS_EN defined, o_bubble_count SHALL:
- increment by 1 on each enabled edge executing a bubble (not a flush)
- saturate at 16'hFFFF
REQ-037 Without ID_EX_BUBBLE_STATS_EN, o_bubble_count SHALL be constant 0 and no counter flops SHALL exist.
REQ-038 All other behaviour SHALL be identical in both builds.

Verification
REQ-039 Reset then capture: reset, then i_valid=1, i_ctrl=11'h007, i_rs_data=32'hA5A5A5A5 -> after one edge o_valid=1, o_ctrl=11'h007, o_rs_data=32'hA5A5A5A5, o_stall=0.
REQ-040 Load-use: EX holds LW (ctrl[4]=1, o_rt_addr=5), ID i_rs_addr=5 -> o_stall=1 same cycle.
- next edge: o_valid=0, o_ctrl=0, o_stall=0
- following edge: ID instruction captured
- o_bubble_count=1 (stats build)
REQ-041 Zero register: EX LW with o_rt_addr=0, ID i_rt_addr=0 -> o_stall=0, no bubble, count unchanged.
REQ-042 Flush beats hazard: hazard condition plus i_flush=1 -> o_stall=0; edge gives o_valid=0, o_bubble_count unchanged.
REQ-043 Enable low: i_enable=0 for 3 edges with hazard present -> all outputs frozen, o_stall stays 1; first edge after i_enable=1 inserts the bubble.
REQ-044 Saturation and reset: force 65536 bubbles -> o_bubble_count=16'hFFFF and holds. Assert i_reset between edges -> all outputs 0 immediately.
